// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment receive/decoder path.
// All glyph patterns are active-low, bit order [6:0] = g..a.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  // Indexed by digit value, so a match at index k decodes to nibble k.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_STABLE = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern into a hex
// nibble plus blank/invalid flags. Invalid and blank both report nibble 0.
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n_i,
  output logic [3:0]       nibble_o,
  output logic             blank_o,
  output logic             invalid_o
);

  // Search the glyph table; anything that is neither a glyph nor blank is invalid.
  always_comb begin
    nibble_o  = 4'h0;
    blank_o   = (seg_n_i == SEG_BLANK);
    invalid_o = (seg_n_i != SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (seg_n_i == GLYPH_TABLE[k]) begin
        nibble_o  = 4'(k);
        invalid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Receive-side monitor for a multi-digit seven-segment bus. The raw bus is
// debounced (a pattern must hold for STABLE_CYCLES samples), then the accepted
// snapshot is decoded into hex digits with a one-cycle pulse on each change.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DISPLAYS  = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                                CLOCK_50_I,
  input  logic                                RESETN_I,
  input  logic [NUM_DISPLAYS-1:0][SEG_W-1:0]  SEVEN_SEGMENT_N_I,
  output logic [4*NUM_DISPLAYS-1:0]           VALUE_O,
  output logic [NUM_DISPLAYS-1:0]             BLANK_O,
  output logic [NUM_DISPLAYS-1:0]             INVALID_O,
  output logic                                UPDATE_O
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [NUM_DISPLAYS-1:0][SEG_W-1:0] sample_q, sample_d;
  logic [NUM_DISPLAYS-1:0][SEG_W-1:0] snap_q;
  logic [7:0]                         cnt_q, cnt_d;
  state_t                             state_q;
  logic                               input_changed;

  logic [4*NUM_DISPLAYS-1:0]          dec_value;
  logic [NUM_DISPLAYS-1:0]            dec_blank;
  logic [NUM_DISPLAYS-1:0]            dec_invalid;

  logic [4*NUM_DISPLAYS-1:0]          value_q;
  logic [NUM_DISPLAYS-1:0]            blank_q;
  logic [NUM_DISPLAYS-1:0]            invalid_q;
  logic                               update_q;

  // Decoders watch the sampled bus so the decoded word is ready on the
  // acceptance edge without an extra pipeline stage.
  generate
    for (genvar gi = 0; gi < NUM_DISPLAYS; gi++) begin : g_digit
      seven_seg_digit_decode u_dec (
        .seg_n_i   (sample_q[gi]),
        .nibble_o  (dec_value[4*gi +: 4]),
        .blank_o   (dec_blank[gi]),
        .invalid_o (dec_invalid[gi])
      );
    end
  endgenerate

  // Stability counter: restart on any bus change, otherwise saturate.
  always_comb begin
    input_changed = (SEVEN_SEGMENT_N_I != sample_q);
    sample_d      = sample_q;
    cnt_d         = cnt_q;
    if (input_changed) begin
      sample_d = SEVEN_SEGMENT_N_I;
      cnt_d    = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Sample register and stability counter.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      sample_q <= {NUM_DISPLAYS{SEG_BLANK}};
      cnt_q    <= 8'd0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
    end
  end

  // Acceptance FSM with registered snapshot, decoded outputs and pulse.
  // If the bus changes on the acceptance edge the old sample is still
  // accepted, but we stay in S_SETTLE so the new value gets its own count.
  always_ff @(posedge CLOCK_50_I) begin
    if (!RESETN_I) begin
      state_q   <= S_SETTLE;
      snap_q    <= {NUM_DISPLAYS{SEG_BLANK}};
      value_q   <= '0;
      blank_q   <= '1;
      invalid_q <= '0;
      update_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (state_q == S_SETTLE) begin
        if (cnt_q == CNT_MAX) begin
          if (sample_q != snap_q) begin
            snap_q    <= sample_q;
            value_q   <= dec_value;
            blank_q   <= dec_blank;
            invalid_q <= dec_invalid;
            update_q  <= 1'b1;
          end
          state_q <= input_changed ? S_SETTLE : S_STABLE;
        end
      end else begin
        if (input_changed) begin
          state_q <= S_SETTLE;
        end
      end
    end
  end

  assign VALUE_O   = value_q;
  assign BLANK_O   = blank_q;
  assign INVALID_O = invalid_q;
  assign UPDATE_O  = update_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder: reset state, acceptance latency,
// multi-digit decode, glitch rejection, invalid glyphs, change on the
// acceptance edge and reset during settling.
module tb_seven_segment_decoder;

  logic             clk;
  logic             resetn;
  logic [7:0][6:0]  seg_n;
  logic [31:0]      value;
  logic [7:0]       blank;
  logic [7:0]       invalid;
  logic             update;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int consec_cnt = 0;
  int base;
  logic prev_update = 1'b0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seven_segment_decoder #(
    .NUM_DISPLAYS  (8),
    .STABLE_CYCLES (4)
  ) dut (
    .CLOCK_50_I        (clk),
    .RESETN_I          (resetn),
    .SEVEN_SEGMENT_N_I (seg_n),
    .VALUE_O           (value),
    .BLANK_O           (blank),
    .INVALID_O         (invalid),
    .UPDATE_O          (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (update) pulse_cnt++;
    if (update && prev_update) consec_cnt++;
    prev_update = update;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=100000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_hex(input logic [31:0] hexval);
    @(negedge clk);
    for (int i = 0; i < 8; i++) seg_n[i] = glyph[hexval[4*i +: 4]];
  endtask

  task automatic drive_blank();
    @(negedge clk);
    for (int i = 0; i < 8; i++) seg_n[i] = 7'h7F;
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) seg_n[i] = 7'h7F;

    // Reset state
    wait_edges(3);
    check("rst_value", value, 32'h0);
    check("rst_blank", {24'h0, blank}, 32'hFF);
    check("rst_invalid", {24'h0, invalid}, 32'h0);
    check("rst_update", {31'h0, update}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    base = pulse_cnt;
    wait_edges(20);
    check("idle_pulses", pulse_cnt - base, 0);
    check("idle_blank", {24'h0, blank}, 32'hFF);
    $display("txn reset/idle: value=%h blank=%h", value, blank);

    // Display 0 = '0', exact latency
    base = pulse_cnt;
    @(negedge clk);
    seg_n[0] = 7'h40;
    wait_edges(4);
    check("lat_early_update", {31'h0, update}, 32'h0);
    check("lat_early_blank", {24'h0, blank}, 32'hFF);
    wait_edges(1);
    check("lat_update", {31'h0, update}, 32'h1);
    check("lat_value", value, 32'h0);
    check("lat_blank", {24'h0, blank}, 32'hFE);
    wait_edges(1);
    check("lat_update_drop", {31'h0, update}, 32'h0);
    wait_edges(8);
    check("lat_pulses", pulse_cnt - base, 1);
    $display("txn digit0: value=%h blank=%h", value, blank);

    // Full eight digit words
    base = pulse_cnt;
    drive_hex(32'h12345678);
    wait_edges(10);
    check("w1_value", value, 32'h12345678);
    check("w1_blank", {24'h0, blank}, 32'h0);
    check("w1_invalid", {24'h0, invalid}, 32'h0);
    check("w1_pulses", pulse_cnt - base, 1);
    $display("txn word: value=%h", value);
    base = pulse_cnt;
    drive_hex(32'hABCDEF09);
    wait_edges(10);
    check("w2_value", value, 32'hABCDEF09);
    check("w2_pulses", pulse_cnt - base, 1);
    $display("txn word: value=%h", value);

    // Glitch rejection
    drive_hex(32'h12345678);
    wait_edges(10);
    base = pulse_cnt;
    @(negedge clk);
    seg_n[2] = 7'h00;
    @(negedge clk);
    @(negedge clk);
    seg_n[2] = glyph[6];
    wait_edges(12);
    check("glitch_pulses", pulse_cnt - base, 0);
    check("glitch_value", value, 32'h12345678);
    $display("txn glitch: value=%h", value);

    // Invalid glyph on display 3
    base = pulse_cnt;
    @(negedge clk);
    seg_n[3] = 7'h55;
    wait_edges(10);
    check("inv_invalid", {24'h0, invalid}, 32'h08);
    check("inv_value", value, 32'h12340678);
    check("inv_blank", {24'h0, blank}, 32'h0);
    check("inv_pulses", pulse_cnt - base, 1);
    $display("txn invalid: value=%h invalid=%h", value, invalid);

    // Input changes exactly on the acceptance edge
    base = pulse_cnt;
    drive_hex(32'h00000000);
    wait_edges(4);
    drive_hex(32'h88888888);
    wait_edges(1);
    check("edge_update1", {31'h0, update}, 32'h1);
    check("edge_value1", value, 32'h00000000);
    wait_edges(3);
    check("edge_gap_update", {31'h0, update}, 32'h0);
    wait_edges(1);
    check("edge_update2", {31'h0, update}, 32'h1);
    check("edge_value2", value, 32'h88888888);
    wait_edges(4);
    check("edge_pulses", pulse_cnt - base, 2);
    $display("txn accept-edge change: value=%h", value);

    // Reset two cycles into settling, released with blank inputs
    base = pulse_cnt;
    drive_hex(32'hFFFFFFFF);
    wait_edges(2);
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 8; i++) seg_n[i] = 7'h7F;
    wait_edges(2);
    check("mrst_value", value, 32'h0);
    check("mrst_blank", {24'h0, blank}, 32'hFF);
    check("mrst_update", {31'h0, update}, 32'h0);
    drive_blank();
    resetn = 1'b1;
    wait_edges(20);
    check("mrst_pulses", pulse_cnt - base, 0);
    check("mrst_blank_after", {24'h0, blank}, 32'hFF);
    check("mrst_invalid_after", {24'h0, invalid}, 32'h0);
    check("no_consecutive_update", consec_cnt, 0);
    $display("txn mid-settle reset: value=%h blank=%h", value, blank);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Board-side monitor that takes the active-low seven-segment drive of the 8 DE2 displays and turns it back into hex digits. It is the receive end of the display path that a lab design drives from its switches. A pattern is accepted only after it has been stable for a set number of clocks, and each new accepted snapshot raises a one-cycle pulse. The block is synthesizable and sits between a lab design's SEVEN_SEGMENT_N_O bus and self-checking logic or LED indicators.

## Interface
- NUM_DISPLAYS, 8: number of displays decoded.
- STABLE_CYCLES, 4: consecutive identical samples required before acceptance; legal range 2..255.

- CLOCK_50_I  in  1  system clock, rising edge.
- RESETN_I  in  1  reset, synchronous, active-low.
- SEVEN_SEGMENT_N_I  in  [NUM_DISPLAYS-1:0][6:0]  active-low segments per display; bit 0 = a … bit 6 = g; display 0 is rightmost.
- VALUE_O  out  4*NUM_DISPLAYS  decoded digits; display i at bits [4i+3:4i].
- BLANK_O  out  NUM_DISPLAYS  display i shows all segments off (7'h7F).
- INVALID_O  out  NUM_DISPLAYS  display i shows a pattern that is neither a hex glyph nor blank.
- UPDATE_O  out  1  one-cycle pulse when the accepted snapshot changes.

## Operation
- Glyph table, active-low, [6:0] = g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
  - blank=7F
- Any other pattern is invalid.
- Decode per display:
  - hex glyph: nibble = digit, BLANK=0, INVALID=0.
  - blank: nibble=0, BLANK=1.
  - invalid: nibble=0, INVALID=1.
- Registers:
  - sample_q: full input bus.
  - cnt: 8-bit, saturating at STABLE_CYCLES-1.
  - snap_q: last accepted raw pattern.
  - FSM state.
- Each edge:
  - If input != sample_q: sample_q <= input, cnt <= 0.
  - Otherwise cnt saturating-increments.
- FSM states:
  - S_SETTLE: counting. When cnt == STABLE_CYCLES-1 and sample_q != snap_q, go to S_STABLE, snap_q <= sample_q, load decoded outputs, UPDATE_O=1 for that cycle. If sample_q == snap_q at saturation, go to S_STABLE with no pulse.
  - S_STABLE: holds outputs. Any input change (cnt reset) goes back to S_SETTLE.
- Glitches shorter than STABLE_CYCLES samples never reach outputs.
- Outputs always reflect snap_q only; they never show intermediate patterns.

## Timing
- Reset values:
  - VALUE_O=0, BLANK_O=all ones, INVALID_O=0, UPDATE_O=0.
  - snap_q=all 7'h7F, sample_q=all 7'h7F, cnt=0, state=S_SETTLE.
- Latency: a new pattern is present before edge 0 and held. It is captured at edge 0 and accepted at edge STABLE_CYCLES. Outputs and UPDATE_O are valid after that edge, i.e. 5 edges for the default.
- UPDATE_O is registered and high for exactly one cycle. It never stays high on consecutive cycles.
- Simultaneous events: if the input changes on the acceptance edge, acceptance of the old sample_q still completes (pulse fires) and counting restarts for the new value.
- A pattern that returns to the current snapshot after a glitch produces no pulse.
- Reset mid-settle or mid-pulse: all registers take reset values on that edge and UPDATE_O drops.
- After reset is released with blank inputs, no pulse occurs.
- cnt saturates; it never wraps.

## Structure
- Package seven_seg_pkg holds:
  - SEG_BLANK and the 16 glyph constants.
  - glyph table array.
  - state_t enum {S_SETTLE, S_STABLE}.
- Sub-module seven_seg_digit_decode: combinational, 7-bit pattern in → nibble, blank, invalid out. It is instantiated NUM_DISPLAYS times via generate on sample_q.
- Top holds sample_q, cnt, FSM, and output registers.

## Test plan
- Reset, all inputs 7'h7F held 20 cycles → BLANK_O=8'hFF, VALUE_O=0, INVALID_O=0, no UPDATE_O pulse.
- Display 0 = 7'h40, rest blank, held → exactly one UPDATE_O pulse 5 cycles after the change; VALUE_O=0, BLANK_O=8'hFE.
- Displays 7..0 driven "1 2 3 4 5 6 7 8" glyphs → VALUE_O=32'h12345678, BLANK_O=0, one pulse. Then switch to "A b C d E F 0 9" → VALUE_O=32'hABCDEF09, second pulse.
- From "12345678", display 2 changed to 7'h00 for 2 cycles then restored → no pulse, VALUE_O unchanged.
- Display 3 = 7'h55 held → INVALID_O=8'h08, nibble [15:12]=0, one pulse.
- Reset asserted 2 cycles into settling on a new pattern, then released with blank inputs → outputs at reset values, no pulse during or after reset.
